instruction_executor: RTL

Downstream consumer of the byte-wise instruction buffer. It latches one completed 32-bit instruction and decodes it. It executes drawing operations as pixel writes into the framebuffer write port, then pulses the buffer's reset so the next instruction can be collected. It sits between the instruction buffer and the framebuffer RAM / VGA scan-out domain, all on one clock.

---
 rtl/instruction_executor.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_executor.sv
// instruction_executor
//   Latches one completed 32-bit instruction from the byte-wise instruction
//   buffer, decodes it and executes drawing operations as pixel writes into
//   the framebuffer write port. When the instruction is finished it pulses
//   o_buf_reset so the buffer can collect the next one.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_reset        synchronous active-high reset
//   i_instruction  instruction word {A, B, C, opcode}, valid while i_ready=1
//   i_ready        buffer holds a complete instruction
//   o_buf_reset    one-cycle pulse returning the buffer to WAITING
//   o_fb_we        framebuffer write strobe
//   o_fb_addr      pixel address, y*FB_WIDTH + x
//   o_fb_data      pixel colour
//   i_fb_stall     framebuffer cannot accept a write this cycle
//   o_busy         high whenever the executor is not idle
//   o_err          one-cycle pulse on illegal opcode or coordinate
module instruction_executor #(
  parameter int         FB_WIDTH      = 160,
  parameter int         FB_HEIGHT     = 120,
  parameter int         ADDR_W        = 15,
  parameter logic [7:0] DEFAULT_COLOR = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_instruction,
  input  logic              i_ready,
  output logic              o_buf_reset,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [7:0]        o_fb_data,
  input  logic              i_fb_stall,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CNT_W = $clog2(FB_WIDTH * FB_HEIGHT + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WRITE,
    DONE,
    WAIT_CLR
  } state_t;

  state_t             state, state_next;
  logic [31:0]        instr, instr_next;
  logic [7:0]         colour, colour_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               fb_we, fb_we_next;
  logic [ADDR_W-1:0]  fb_addr, fb_addr_next;
  logic [7:0]         fb_data, fb_data_next;
  logic               buf_reset, buf_reset_next;
  logic               busy, busy_next;
  logic               err, err_next;

  logic [7:0]         opcode, arg_a, arg_b, arg_c;
  logic               dec_err, dec_set_colour;
  logic [CNT_W-1:0]   dec_count;
  logic [ADDR_W-1:0]  dec_start;
  logic [7:0]         dec_data;
  int                 room;

  assign opcode = instr[7:0];
  assign arg_a  = instr[31:24];
  assign arg_b  = instr[23:16];
  assign arg_c  = instr[15:8];

  // Decode of the latched instruction: start address, number of writes,
  // write colour and error flag. Only consumed during DECODE.
  always_comb begin
    dec_err        = 1'b0;
    dec_set_colour = 1'b0;
    dec_count      = '0;
    dec_start      = '0;
    dec_data       = colour;
    room           = FB_WIDTH - int'(arg_a);
    case (opcode)
      8'h00: ;
      8'h01: dec_set_colour = 1'b1;
      8'h02: begin
        if (int'(arg_a) >= FB_WIDTH || int'(arg_b) >= FB_HEIGHT) begin
          dec_err = 1'b1;
        end else begin
          dec_start = ADDR_W'(int'(arg_b) * FB_WIDTH + int'(arg_a));
          dec_count = CNT_W'(1);
          dec_data  = arg_c;
        end
      end
      8'h03: begin
        dec_set_colour = 1'b1;
        dec_count      = CNT_W'(FB_WIDTH * FB_HEIGHT);
        dec_data       = arg_c;
      end
      8'h04: begin
        if (int'(arg_a) >= FB_WIDTH || int'(arg_b) >= FB_HEIGHT) begin
          dec_err = 1'b1;
        end else begin
          // Clip at the right edge so a long line never wraps to the next row.
          dec_start = ADDR_W'(int'(arg_b) * FB_WIDTH + int'(arg_a));
          dec_count = (int'(arg_c) < room) ? CNT_W'(arg_c) : CNT_W'(room);
        end
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so the ports never carry combinational paths.
  always_comb begin
    state_next     = state;
    instr_next     = instr;
    colour_next    = colour;
    count_next     = count;
    fb_we_next     = fb_we;
    fb_addr_next   = fb_addr;
    fb_data_next   = fb_data;
    buf_reset_next = 1'b0;
    err_next       = 1'b0;
    case (state)
      IDLE: begin
        if (i_ready) begin
          instr_next = i_instruction;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (dec_set_colour) colour_next = arg_c;
        if (dec_err || dec_count == '0) begin
          buf_reset_next = 1'b1;
          err_next       = dec_err;
          state_next     = DONE;
        end else begin
          fb_we_next   = 1'b1;
          fb_addr_next = dec_start;
          fb_data_next = dec_data;
          count_next   = dec_count;
          state_next   = WRITE;
        end
      end
      WRITE: begin
        // A stalled cycle leaves address, data and strobe untouched.
        if (!i_fb_stall) begin
          fb_addr_next = fb_addr + ADDR_W'(1);
          count_next   = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            fb_we_next     = 1'b0;
            buf_reset_next = 1'b1;
            state_next     = DONE;
          end
        end
      end
      DONE:     state_next = WAIT_CLR;
      // The buffer's ready drops one cycle after its reset; waiting here
      // stops the old instruction from being executed twice.
      WAIT_CLR: if (!i_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers with synchronous reset. Reset aborts any
  // operation at once and does not pulse o_buf_reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      instr     <= '0;
      colour    <= DEFAULT_COLOR;
      count     <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      buf_reset <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      instr     <= instr_next;
      colour    <= colour_next;
      count     <= count_next;
      fb_we     <= fb_we_next;
      fb_addr   <= fb_addr_next;
      fb_data   <= fb_data_next;
      buf_reset <= buf_reset_next;
      busy      <= busy_next;
      err       <= err_next;
    end
  end

  assign o_buf_reset = buf_reset;
  assign o_fb_we     = fb_we;
  assign o_fb_addr   = fb_addr;
  assign o_fb_data   = fb_data;
  assign o_busy      = busy;
  assign o_err       = err;

endmodule
